piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter for the Guia5 shift-register set. It is the sending end of the 4-bit serial-in parallel-out receiver.
- Captures a WIDTH-bit word on a load request.
- Shifts the word out MSB-first, one bit per enabled clock.
- Reports `busy` while shifting and pulses `done` when the word has left.

Driving `S_out` into the receiver's serial input, on the same `clk` and `enable`, reproduces `P_in` on the receiver's parallel output once `done` is asserted.

## Interface
- `WIDTH`, default 4: word length in bits. Legal range is 2 to 32.
- `clk`  in  1: single clock. All state updates on its rising edge.
- `reset`  in  1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `enable`  in  1: bit-advance qualifier. Shifting advances only on edges where `enable`=1.
- `load`  in  1: request to capture `P_in` and start a frame.
- `P_in`  in  WIDTH: parallel word to transmit.
- `S_out`  out  1: serial data. The MSB is sent first.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse after the last bit of a frame is consumed.

## Operation
- States:
  - IDLE.
  - SHIFT.
  - PARITY (exists only with `PISO_PARITY_EN`).
- Reset (`reset`=0 at an edge): state becomes IDLE. `shreg`=0, `cnt`=0, `S_out`=0, `busy`=0, `done`=0. Reset overrides every other input, including mid-frame.
- In IDLE:
  - `S_out`=0 and `busy`=0.
  - `load`=1 at an edge: `shreg` <= `P_in`, `cnt` <= 0, state goes to SHIFT.
  - `load` is accepted independently of `enable`.
- In SHIFT:
  - `S_out` = `shreg[WIDTH-1]` and `busy`=1.
  - On an edge with `enable`=1: `shreg` shifts left by one with 0 filled in at the LSB, and `cnt` increments.
  - On an edge with `enable`=0: everything holds.
- Last data bit: an enabled edge with `cnt`=WIDTH-1 ends the data phase.
  - Without parity: go to IDLE and set `done`=1 for the next cycle.
  - With parity: go to PARITY.
- `load` while `busy`=1 is ignored, including on the cycle of the final bit. The word must be re-presented after `done`.
- `done` is registered. It is high for exactly one cycle and is 0 in every other cycle.
- `cnt` is $clog2(WIDTH) bits wide and never wraps. It is cleared only on load or reset.
- `P_in` changes after load have no effect on the frame in progress.

## Timing
- `load` accepted at edge t:
  - `busy`=1 and `S_out`=`P_in[WIDTH-1]` from cycle t+1.
  - Bit k (MSB=0) is valid from the (k)th enabled edge after t up to the (k+1)th enabled edge.
- With `enable` held high, data bits occupy WIDTH cycles. `done` is high in cycle t+WIDTH+1 and `busy` drops in the same cycle.
- A downstream receiver sampling on the same enabled edges holds the full word after WIDTH enabled edges.
- Minimum spacing between accepted loads is WIDTH+1 cycles (WIDTH+2 with parity).
- `S_out`, `busy` and `done` are decoded from registers only. There is no combinational path from any input to any output.

## Configuration
- Macro: `PISO_PARITY_EN`.
- Defined:
  - At load, `par` <= ^`P_in` (the even-parity bit).
  - After the last data bit, the PARITY state drives `S_out`=`par` with `busy`=1 for one enabled cycle.
  - The enabled edge in PARITY returns to IDLE and pulses `done`.
  - The frame is WIDTH+1 bits long.
- Undefined: there is no PARITY state and no `par` register, and the frame is WIDTH bits long.

## Structure
- Shared package `piso_pkg` holds:
  - State encodings IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - The counter-width helper constant.
  - The default WIDTH.
- Sub-module `piso_bit_counter`, parameterized by WIDTH:
  - Inputs: clear, advance.
  - Output: terminal flag `cnt`==WIDTH-1.
  - Instantiated once.
- `shreg` and the state register live in the top module.

## Test plan
- WIDTH=4, `enable`=1, load 4'b1011 -> `S_out` is 1,0,1,1 on the next 4 cycles, then `done`=1 for one cycle, then `busy`=0 and `S_out`=0.
- Same frame with `enable` toggling 1,0,1,0 -> each bit is held across the disabled edges. `done` arrives after the 4th enabled edge, 8 cycles after load.
- Load 4'b0110, then assert `load` with 4'b1111 on cycles 2 and 4 of the frame -> the second word is ignored, the stream is 0,1,1,0 and there is a single `done`.
- Reset low on cycle 2 of a frame -> the next cycle shows `busy`=0, `S_out`=0, `done`=0. A fresh load of 4'b1000 then transmits correctly.
- Loopback into the 4-bit serial-in parallel-out receiver on a shared `clk`/`enable`, with random words -> receiver parallel output == `P_in` in the cycle `done`=1, 200 words without a mismatch.
- With `PISO_PARITY_EN`, load 4'b1011 -> `S_out` is 1,0,1,1,1 and `done` comes after 5 enabled edges. Load 4'b1001 -> the parity bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encodings, default width and counter-width helper for piso_tx
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_bits(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: data-bit counter that flags the last bit of a frame and never wraps
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic last
);

    localparam int CW = cnt_bits(WIDTH);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WIDTH - 1));

    // count enabled shifts; clear on load, saturate at the terminal value
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (advance && !last)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first; PISO_PARITY_EN appends an even-parity bit
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] P_in,
    output logic             S_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic             last, done_next, start, shifting;

    assign start    = (state == IDLE) && load;
    assign shifting = (state == SHIFT) && enable;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .advance (shifting),
        .last    (last)
    );

`ifdef PISO_PARITY_EN
    logic par;

    // latch the even-parity bit of the word when it is captured
    always_ff @(posedge clk) begin
        if (!reset)
            par <= 1'b0;
        else if (start)
            par <= ^P_in;
    end

    assign S_out = (state == SHIFT) ? shreg[WIDTH-1] : (state == PARITY) ? par : 1'b0;
`else
    assign S_out = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
`endif

    assign busy = (state != IDLE);

    // next-state and done decode
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:  if (load) state_next = SHIFT;
            SHIFT: if (enable && last) begin
`ifdef PISO_PARITY_EN
                state_next = PARITY;
`else
                state_next = IDLE;
                done_next  = 1'b1;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: if (enable) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // state, shift register and registered done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (start)
                shreg <= P_in;
            else if (shifting)
                shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx at WIDTH=4
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, load;
    logic [3:0] P_in;
    logic       S_out, busy, done;
    logic [3:0] rx;
    int         checks = 0;
    int         failures = 0;

    piso_tx #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .P_in   (P_in),
        .S_out  (S_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // reference 4-bit serial-in parallel-out receiver
    always @(posedge clk) begin
        if (!reset)
            rx <= 4'd0;
        else if (enable)
            rx <= {rx[2:0], S_out};
    end

    function automatic logic exp_bit(input logic [3:0] w, input int k);
        return (k < 4) ? w[3-k] : ^w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input logic [3:0] w);
        enable = 1'b1;
        load   = 1'b1;
        P_in   = w;
        tick();
        load = 1'b0;
        P_in = ~w;
        for (int k = 0; k < FRAME; k++) begin
            chk("frame_bit", S_out, exp_bit(w, k));
            chk("frame_busy", busy, 1'b1);
            chk("frame_done_low", done, 1'b0);
            tick();
        end
        chk("frame_done", done, 1'b1);
        chk("frame_busy_end", busy, 1'b0);
        chk("frame_sout_end", S_out, 1'b0);
        tick();
        chk("frame_done_once", done, 1'b0);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        P_in   = 4'hF;
        tick();
        tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_sout", S_out, 1'b0);
        chk("reset_done", done, 1'b0);
        reset = 1'b1;
        load  = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic test_patterns();
        run_frame(4'b1011);
        run_frame(4'b1001);
        run_frame(4'b0001);
        run_frame(4'b1110);
    endtask

    task automatic test_enable_gap();
        int k;
        k      = 0;
        enable = 1'b1;
        load   = 1'b1;
        P_in   = 4'b1011;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME - 1; i++) begin
            enable = (i % 2 == 0);
            chk("gap_bit", S_out, exp_bit(4'b1011, k));
            chk("gap_busy", busy, 1'b1);
            chk("gap_done_low", done, 1'b0);
            tick();
            if (enable) k++;
        end
        enable = 1'b0;
        chk("gap_done", done, 1'b1);
        chk("gap_busy_end", busy, 1'b0);
        tick();
        chk("gap_done_once", done, 1'b0);
    endtask

    task automatic test_load_ignored();
        enable = 1'b1;
        load   = 1'b1;
        P_in   = 4'b0110;
        tick();
        load = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            load = (k == 1 || k == 3);
            P_in = 4'b1111;
            chk("ign_bit", S_out, exp_bit(4'b0110, k));
            chk("ign_done_low", done, 1'b0);
            tick();
        end
        load = 1'b0;
        chk("ign_done", done, 1'b1);
        tick();
        chk("ign_done_once", done, 1'b0);
        chk("ign_no_restart", busy, 1'b0);
    endtask

    task automatic test_mid_reset();
        enable = 1'b1;
        load   = 1'b1;
        P_in   = 4'b1011;
        tick();
        load = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_sout", S_out, 1'b0);
        chk("mid_reset_done", done, 1'b0);
        run_frame(4'b1000);
    endtask

    task automatic test_loopback();
        logic [3:0] w, exp_rx;
        int         t;
        for (int n = 0; n < 200; n++) begin
            w      = 4'($urandom_range(0, 15));
            enable = 1'($urandom_range(0, 1));
            load   = 1'b1;
            P_in   = w;
            tick();
            load = 1'b0;
            P_in = 4'($urandom_range(0, 15));
            t    = 0;
            while (!done && t < 100) begin
                enable = 1'($urandom_range(0, 1));
                tick();
                t++;
            end
`ifdef PISO_PARITY_EN
            exp_rx = {w[2:0], ^w};
`else
            exp_rx = w;
`endif
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL loopback_timeout: word %h no done after %0d cycles", w, t);
            end else if (rx !== exp_rx) begin
                failures++;
                $display("FAIL loopback_word: got %h expected %h", rx, exp_rx);
            end
            enable = 1'b1;
            tick();
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        P_in   = 4'd0;
        test_reset();
        test_patterns();
        test_enable_gap();
        test_load_ignored();
        test_mid_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
